// File: rtl/l1d_cache_rle.sv
// l1d_cache_rle: write-through set-associative L1 data cache
// with per-set FIFO replacement and run-length-encoded line fills.
module l1d_cache_rle #(
  parameter int SETS           = 16,
  parameter int WAYS           = 4,
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WRITE_ALLOCATE = 0
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              REQ_VALID,
  output logic                              REQ_READY,
  input  logic                              REQ_WRITE,
  input  logic [ADDR_W-1:0]                 REQ_ADDR,
  input  logic [DATA_W-1:0]                 REQ_WDATA,
  output logic                              RESP_VALID,
  output logic [DATA_W-1:0]                 RESP_RDATA,
  output logic                              RESP_HIT,
  output logic                              MEM_REQ_VALID,
  input  logic                              MEM_REQ_READY,
  output logic                              MEM_REQ_WRITE,
  output logic [ADDR_W-1:0]                 MEM_REQ_ADDR,
  output logic [DATA_W-1:0]                 MEM_REQ_WDATA,
  input  logic                              MEM_RESP_VALID,
  input  logic [DATA_W-1:0]                 MEM_RESP_DATA,
  input  logic [$clog2(WORDS_PER_LINE):0]   MEM_RESP_COUNT,
  input  logic                              MEM_WR_DONE,
  output logic [31:0]                       HIT_COUNT,
  output logic [31:0]                       MISS_COUNT
);

  localparam int OB  = $clog2(WORDS_PER_LINE);
  localparam int IB  = $clog2(SETS);
  localparam int WB  = $clog2(WAYS);
  localparam int TW  = ADDR_W - OB - IB;
  localparam int FPW = OB + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_FILL,
    S_INSTALL, S_WR_REQ, S_WR_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] data_q [SETS][WAYS][WORDS_PER_LINE];
  logic [TW-1:0]     tag_q  [SETS][WAYS];
  logic [WAYS-1:0]   vld_q  [SETS];
  logic [WB-1:0]     fifo_q [SETS];
  logic [DATA_W-1:0] buf_q  [WORDS_PER_LINE];

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              hit_q;
  logic [FPW-1:0]    fill_ptr_q;

  logic [IB-1:0]  set_idx;
  logic [OB-1:0]  off;
  logic [TW-1:0]  tag;
  logic           hit;
  logic [WB-1:0]  hit_way;
  logic [WB-1:0]  vic;
  logic           vic_free;
  logic [FPW-1:0] cnt_eff;
  logic [FPW-1:0] fill_end;

  assign set_idx  = addr_q[OB +: IB];
  assign off      = addr_q[OB-1:0];
  assign tag      = addr_q[ADDR_W-1 -: TW];
  assign cnt_eff  = (MEM_RESP_COUNT == '0) ? FPW'(1)
                                           : FPW'(MEM_RESP_COUNT);
  assign fill_end = fill_ptr_q + cnt_eff;

  // tag compare across all ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld_q[set_idx][w] && tag_q[set_idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
    end
  end

  // victim: lowest free way, else the set's FIFO pointer
  always_comb begin
    vic      = fifo_q[set_idx];
    vic_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld_q[set_idx][w]) begin
        vic      = WB'(w);
        vic_free = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (REQ_VALID) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)
          state_d = write_q ? S_WR_REQ : S_IDLE;
        else if (!write_q || WRITE_ALLOCATE != 0)
          state_d = S_MISS_REQ;
        else
          state_d = S_WR_REQ;
      end
      S_MISS_REQ: if (MEM_REQ_READY) state_d = S_FILL;
      S_FILL: begin
        if (MEM_RESP_VALID &&
            fill_end >= FPW'(WORDS_PER_LINE))
          state_d = S_INSTALL;
      end
      S_INSTALL:  state_d = write_q ? S_WR_REQ : S_IDLE;
      S_WR_REQ:   if (MEM_REQ_READY) state_d = S_WR_WAIT;
      S_WR_WAIT:  if (MEM_WR_DONE) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // handshake and memory request outputs
  always_comb begin
    REQ_READY     = (state_q == S_IDLE);
    MEM_REQ_VALID = (state_q == S_MISS_REQ) ||
                    (state_q == S_WR_REQ);
    MEM_REQ_WRITE = (state_q == S_WR_REQ);
    MEM_REQ_ADDR  = MEM_REQ_WRITE ? addr_q
                  : {addr_q[ADDR_W-1:OB], {OB{1'b0}}};
    MEM_REQ_WDATA = wdata_q;
  end

  // valid bits, FIFO pointers, counters and responses
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < SETS; s++) begin
        vld_q[s]  <= '0;
        fifo_q[s] <= '0;
      end
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
      RESP_VALID <= 1'b0;
      RESP_RDATA <= '0;
      RESP_HIT   <= 1'b0;
      hit_q      <= 1'b0;
      fill_ptr_q <= '0;
    end else begin
      RESP_VALID <= 1'b0;
      unique case (state_q)
        S_LOOKUP: begin
          hit_q <= hit;
          if (hit) begin
            if (HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + 32'd1;
            if (!write_q) begin
              RESP_VALID <= 1'b1;
              RESP_HIT   <= 1'b1;
              RESP_RDATA <= data_q[set_idx][hit_way][off];
            end
          end else begin
            if (MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + 32'd1;
          end
        end
        S_MISS_REQ: fill_ptr_q <= '0;
        S_FILL: if (MEM_RESP_VALID) fill_ptr_q <= fill_end;
        S_INSTALL: begin
          vld_q[set_idx][vic] <= 1'b1;
          if (!vic_free) fifo_q[set_idx] <= fifo_q[set_idx] + WB'(1);
          if (!write_q) begin
            RESP_VALID <= 1'b1;
            RESP_HIT   <= 1'b0;
            RESP_RDATA <= buf_q[off];
          end
        end
        S_WR_WAIT: begin
          if (MEM_WR_DONE) begin
            RESP_VALID <= 1'b1;
            RESP_HIT   <= hit_q;
          end
        end
        default: ;
      endcase
    end
  end

  // request latch, fill buffer and data/tag arrays
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state_q == S_IDLE && REQ_VALID) begin
        addr_q  <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
        write_q <= REQ_WRITE;
      end
      if (state_q == S_LOOKUP && hit && write_q)
        data_q[set_idx][hit_way][off] <= wdata_q;
      if (state_q == S_FILL && MEM_RESP_VALID) begin
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
          if (FPW'(i) >= fill_ptr_q && FPW'(i) < fill_end)
            buf_q[i] <= MEM_RESP_DATA;
        end
      end
      if (state_q == S_INSTALL) begin
        tag_q[set_idx][vic] <= tag;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
          data_q[set_idx][vic][i] <=
            (write_q && OB'(i) == off) ? wdata_q : buf_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_l1d_cache_rle.sv
// tb_l1d_cache_rle: randomized and directed checks of l1d_cache_rle
// against a per-set age-ordered line model (one DUT per allocate mode).
module tb_l1d_cache_rle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [2];
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_write   [2];
  logic [31:0] req_addr    [2];
  logic [31:0] req_wdata   [2];
  logic        resp_valid  [2];
  logic [31:0] resp_rdata  [2];
  logic        resp_hit    [2];
  logic        mreq_valid  [2];
  logic        mreq_ready  [2];
  logic        mreq_write  [2];
  logic [31:0] mreq_addr   [2];
  logic [31:0] mreq_wdata  [2];
  logic        mresp_valid [2];
  logic [31:0] mresp_data  [2];
  logic [3:0]  mresp_cnt   [2];
  logic        mwr_done    [2];
  logic [31:0] hit_cnt     [2];
  logic [31:0] miss_cnt    [2];

  l1d_cache_rle #(.WRITE_ALLOCATE(0)) u0 (
    .CLK(clk), .RESET(rst[0]),
    .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
    .REQ_WRITE(req_write[0]), .REQ_ADDR(req_addr[0]),
    .REQ_WDATA(req_wdata[0]),
    .RESP_VALID(resp_valid[0]), .RESP_RDATA(resp_rdata[0]),
    .RESP_HIT(resp_hit[0]),
    .MEM_REQ_VALID(mreq_valid[0]), .MEM_REQ_READY(mreq_ready[0]),
    .MEM_REQ_WRITE(mreq_write[0]), .MEM_REQ_ADDR(mreq_addr[0]),
    .MEM_REQ_WDATA(mreq_wdata[0]),
    .MEM_RESP_VALID(mresp_valid[0]), .MEM_RESP_DATA(mresp_data[0]),
    .MEM_RESP_COUNT(mresp_cnt[0]), .MEM_WR_DONE(mwr_done[0]),
    .HIT_COUNT(hit_cnt[0]), .MISS_COUNT(miss_cnt[0])
  );

  l1d_cache_rle #(.WRITE_ALLOCATE(1)) u1 (
    .CLK(clk), .RESET(rst[1]),
    .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
    .REQ_WRITE(req_write[1]), .REQ_ADDR(req_addr[1]),
    .REQ_WDATA(req_wdata[1]),
    .RESP_VALID(resp_valid[1]), .RESP_RDATA(resp_rdata[1]),
    .RESP_HIT(resp_hit[1]),
    .MEM_REQ_VALID(mreq_valid[1]), .MEM_REQ_READY(mreq_ready[1]),
    .MEM_REQ_WRITE(mreq_write[1]), .MEM_REQ_ADDR(mreq_addr[1]),
    .MEM_REQ_WDATA(mreq_wdata[1]),
    .MEM_RESP_VALID(mresp_valid[1]), .MEM_RESP_DATA(mresp_data[1]),
    .MEM_RESP_COUNT(mresp_cnt[1]), .MEM_WR_DONE(mwr_done[1]),
    .HIT_COUNT(hit_cnt[1]), .MISS_COUNT(miss_cnt[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: per set, resident lines ordered oldest first
  int          nl   [2][16];
  logic [24:0] mtag [2][16][4];
  logic [31:0] mdat [2][16][4][8];
  int          mhits[2];
  int          mmiss[2];

  logic [31:0] fline [8];
  logic [31:0] fq_d [$];
  int          fq_c [$];
  bit          force_stray = 1'b0;
  logic [31:0] last_rdata;
  logic        last_hit;
  logic [31:0] last_fill_addr;

  function automatic int mfind(input int s, input logic [31:0] a);
    int st = int'(a[6:3]);
    for (int k = 0; k < nl[s][st]; k++)
      if (mtag[s][st][k] == a[31:7]) return k;
    return -1;
  endfunction

  function automatic void minstall(input int s, input logic [31:0] a);
    int st = int'(a[6:3]);
    if (nl[s][st] == 4) begin
      for (int k = 0; k < 3; k++) begin
        mtag[s][st][k] = mtag[s][st][k+1];
        for (int i = 0; i < 8; i++) mdat[s][st][k][i] = mdat[s][st][k+1][i];
      end
      nl[s][st] = 3;
    end
    mtag[s][st][nl[s][st]] = a[31:7];
    for (int i = 0; i < 8; i++) mdat[s][st][nl[s][st]][i] = fline[i];
    nl[s][st]++;
  endfunction

  function automatic void mreset(input int s);
    for (int i = 0; i < 16; i++) nl[s][i] = 0;
    mhits[s] = 0;
    mmiss[s] = 0;
  endfunction

  task automatic do_reset(input int s);
    rst[s] = 1'b1;
    repeat (2) @(negedge clk);
    rst[s] = 1'b0;
    mreset(s);
    chk("rst_ready", req_ready[s], 1);
    chk("rst_resp", resp_valid[s], 0);
    chk("rst_mreq", mreq_valid[s], 0);
    chk("rst_rdata", resp_rdata[s], 0);
    chk("rst_hcnt", hit_cnt[s], 0);
    chk("rst_mcnt", miss_cnt[s], 0);
  endtask

  // serve one line fill as RLE beats; t marks the completing beat
  task automatic send_fill(input int s, output time t);
    int p = 0;
    int c;
    int e;
    logic [31:0] d;
    while (p < 8) begin
      if (fq_c.size() > 0) begin
        c = fq_c.pop_front();
        d = fq_d.pop_front();
      end else begin
        c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                        : int'($urandom_range(0, 3));
        d = $urandom;
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      mresp_valid[s] = 1'b1;
      mresp_data[s]  = d;
      mresp_cnt[s]   = 4'(c);
      @(negedge clk);
      mresp_valid[s] = 1'b0;
      e = (c == 0) ? 1 : c;
      for (int i = p; i < p + e && i < 8; i++) fline[i] = d;
      p += e;
    end
    t = $time;
    if (force_stray || $urandom_range(0, 2) == 0) begin
      mresp_valid[s] = 1'b1;
      mresp_data[s]  = $urandom;
      mresp_cnt[s]   = 4'd9;
      @(negedge clk);
      mresp_valid[s] = 1'b0;
    end
  endtask

  task automatic do_req(input int s, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd);
    int  k;
    int  st;
    bit  hit;
    bit  exp_fill;
    int  fills = 0;
    int  wrs = 0;
    int  cyc = 0;
    int  first_mreq = -1;
    bit  done = 1'b0;
    bit  acted;
    bit  was_wr;
    time t_inst = 0;
    logic [31:0] exp_rd;
    st = int'(a[6:3]);
    k = mfind(s, a);
    hit = (k >= 0);
    exp_fill = !hit && (!wr || s == 1);
    if (hit) mhits[s]++;
    else     mmiss[s]++;
    chk("req_ready", req_ready[s], 1);
    req_valid[s] = 1'b1;
    req_write[s] = wr;
    req_addr[s]  = a;
    req_wdata[s] = wd;
    @(negedge clk);
    req_valid[s] = 1'b0;
    while (!done && cyc < 300) begin
      acted = 1'b0;
      if (resp_valid[s]) begin
        done = 1'b1;
        exp_rd = hit ? mdat[s][st][k][a[2:0]] : fline[a[2:0]];
        chk("resp_hit", resp_hit[s], hit);
        if (!wr) begin
          chk("rdata", resp_rdata[s], exp_rd);
          chk("ready_at_resp", req_ready[s], 1);
          if (hit) chk("hit_lat", cyc, 1);
          else     chk("install_lat", $time - t_inst, 10);
        end
        chk("n_fills", fills, exp_fill);
        chk("n_writes", wrs, wr);
        chk("hit_count", hit_cnt[s], mhits[s]);
        chk("miss_count", miss_cnt[s], mmiss[s]);
        last_rdata = resp_rdata[s];
        last_hit   = resp_hit[s];
      end else if (mreq_valid[s]) begin
        if (first_mreq < 0) begin
          first_mreq = cyc;
          chk("mreq_lat", cyc, 1);
        end
        if (mreq_write[s]) begin
          chk("wr_addr", mreq_addr[s], a);
          chk("wr_data", mreq_wdata[s], wd);
        end else begin
          chk("fill_addr", mreq_addr[s], {a[31:3], 3'b000});
          last_fill_addr = mreq_addr[s];
        end
        if ($urandom_range(0, 2) != 0) begin
          acted = 1'b1;
          was_wr = mreq_write[s];
          mreq_ready[s] = 1'b1;
          @(negedge clk);
          mreq_ready[s] = 1'b0;
          if (was_wr) begin
            wrs++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            mwr_done[s] = 1'b1;
            @(negedge clk);
            mwr_done[s] = 1'b0;
          end else begin
            fills++;
            send_fill(s, t_inst);
          end
        end
      end
      if (!acted) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) chk("resp_timeout", 0, 1);
    if (exp_fill) begin
      if (wr) fline[a[2:0]] = wd;
      minstall(s, a);
    end else if (hit && wr) begin
      mdat[s][st][k][a[2:0]] = wd;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 5) << 7) | ($urandom_range(0, 15) << 3)
      | $urandom_range(0, 7);
    return a;
  endfunction

  logic [31:0] ev_addr [5];

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1;
      req_valid[s] = 1'b0;
      req_write[s] = 1'b0;
      req_addr[s] = '0;
      req_wdata[s] = '0;
      mreq_ready[s] = 1'b0;
      mresp_valid[s] = 1'b0;
      mresp_data[s] = '0;
      mresp_cnt[s] = '0;
      mwr_done[s] = 1'b0;
    end
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // miss with two RLE beats, then hit
    fq_d.push_back(32'hAAAA0000); fq_c.push_back(3);
    fq_d.push_back(32'hBBBB0000); fq_c.push_back(5);
    do_req(0, 1'b0, 32'h123, 32'h0);
    chk("tp_fill_addr", last_fill_addr, 32'h120);
    chk("tp_miss_rdata", last_rdata, 32'hBBBB0000);
    chk("tp_miss_hit", last_hit, 0);
    chk("tp_miss_cnt", miss_cnt[0], 1);
    do_req(0, 1'b0, 32'h121, 32'h0);
    chk("tp_hit_rdata", last_rdata, 32'hAAAA0000);
    chk("tp_hit_cnt", hit_cnt[0], 1);

    // write hit then read back
    do_req(0, 1'b1, 32'h123, 32'h12345678);
    chk("tp_wr_hit", last_hit, 1);
    do_req(0, 1'b0, 32'h123, 32'h0);
    chk("tp_rd_after_wr", last_rdata, 32'h12345678);

    // no-allocate write miss, then read misses
    do_req(0, 1'b1, 32'h200, 32'hCAFE0001);
    do_req(0, 1'b0, 32'h200, 32'h0);
    chk("tp_noalloc_miss", last_hit, 0);

    // oversize run and zero-count run
    fq_d.push_back(32'hD00D0009); fq_c.push_back(9);
    force_stray = 1'b1;
    do_req(0, 1'b0, 32'h300, 32'h0);
    force_stray = 1'b0;
    do_req(0, 1'b0, 32'h307, 32'h0);
    chk("tp_cnt9_word7", last_rdata, 32'hD00D0009);
    fq_d.push_back(32'hE0E0E0E0); fq_c.push_back(0);
    fq_d.push_back(32'hF0F0F0F0); fq_c.push_back(9);
    do_req(0, 1'b0, 32'h400, 32'h0);
    chk("tp_cnt0_word0", last_rdata, 32'hE0E0E0E0);
    do_req(0, 1'b0, 32'h401, 32'h0);
    chk("tp_cnt0_word1", last_rdata, 32'hF0F0F0F0);

    // FIFO eviction in set 4
    do_reset(0);
    ev_addr = '{32'h0A0, 32'h120, 32'h1A0, 32'h220, 32'h2A0};
    foreach (ev_addr[i]) do_req(0, 1'b0, ev_addr[i], 32'h0);
    do_req(0, 1'b0, 32'h120, 32'h0);
    chk("tp_evict_keep", last_hit, 1);
    do_req(0, 1'b0, 32'h0A0, 32'h0);
    chk("tp_evict_gone", last_hit, 0);

    // reset in the middle of a fill
    do_reset(0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h500;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("mid_mreq", mreq_valid[0], 1);
    mreq_ready[0] = 1'b1;
    @(negedge clk);
    mreq_ready[0] = 1'b0;
    mresp_valid[0] = 1'b1;
    mresp_data[0]  = 32'h11110000;
    mresp_cnt[0]   = 4'd3;
    @(negedge clk);
    mresp_valid[0] = 1'b0;
    do_reset(0);
    mresp_valid[0] = 1'b1;
    mresp_cnt[0]   = 4'd5;
    @(negedge clk);
    mresp_valid[0] = 1'b0;
    @(negedge clk);
    chk("stray_resp", resp_valid[0], 0);
    chk("stray_ready", req_ready[0], 1);
    do_req(0, 1'b0, 32'h500, 32'h0);
    chk("mid_rst_miss", last_hit, 0);
    chk("mid_rst_mcnt", miss_cnt[0], 1);

    // write-allocate: fill, merge, write-through, then hit
    do_req(1, 1'b1, 32'h200, 32'h5A5A5A5A);
    do_req(1, 1'b0, 32'h200, 32'h0);
    chk("wa_hit", last_hit, 1);
    chk("wa_rdata", last_rdata, 32'h5A5A5A5A);

    // randomized traffic on both modes
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 150; n++) begin
        do_req(s, ($urandom_range(0, 2) == 0), rnd_addr(), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
